// File: rtl/rob_queue_if.sv
// rob_queue_if: issue, writeback and commit signals of the reorder buffer
interface rob_queue_if #(
  parameter int DEPTH  = 8,
  parameter int NSRC   = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int TAG_W  = $clog2(DEPTH)
);
  logic                   alloc_valid;
  logic [REG_W-1:0]       alloc_rd;
  logic                   alloc_ready;
  logic [TAG_W-1:0]       alloc_tag;
  logic [NSRC-1:0]        wb_valid;
  logic [NSRC*TAG_W-1:0]  wb_tag;
  logic [NSRC*DATA_W-1:0] wb_data;
  logic [NSRC-1:0]        wb_jump;
  logic [NSRC*ADDR_W-1:0] wb_target;
  logic                   cmt_valid;
  logic [REG_W-1:0]       cmt_rd;
  logic [DATA_W-1:0]      cmt_data;
  logic [TAG_W-1:0]       cmt_tag;
  logic                   pc_we;
  logic [ADDR_W-1:0]      pc_newpc;
  logic                   flush;
  logic [TAG_W:0]         count;
  logic                   empty;
  logic                   full;
  modport master (
    output alloc_valid, alloc_rd, wb_valid, wb_tag, wb_data, wb_jump, wb_target,
    input  alloc_ready, alloc_tag, cmt_valid, cmt_rd, cmt_data, cmt_tag,
           pc_we, pc_newpc, flush, count, empty, full
  );
  modport slave (
    input  alloc_valid, alloc_rd, wb_valid, wb_tag, wb_data, wb_jump, wb_target,
    output alloc_ready, alloc_tag, cmt_valid, cmt_rd, cmt_data, cmt_tag,
           pc_we, pc_newpc, flush, count, empty, full
  );
endinterface

// File: rtl/rob_queue.sv
// rob_queue: circular reorder buffer, out-of-order writeback, in-order commit; ROB_BYPASS_EN lets a head writeback commit in the same cycle
module rob_queue #(
  parameter int DEPTH  = 8,
  parameter int NSRC   = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input logic       clk,
  input logic       rst,
  rob_queue_if.slave bus
);
  logic [DEPTH-1:0]  busy, done, jump_q;
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] tgt_q  [DEPTH];
  logic [TAG_W-1:0]  head, tail;
  logic [DEPTH-1:0]  hit, hit_jump;
  logic [DATA_W-1:0] hit_data [DEPTH];
  logic [ADDR_W-1:0] hit_tgt  [DEPTH];
  logic              byp, commit, c_jump, alloc;
  logic [DATA_W-1:0] c_data;
  logic [ADDR_W-1:0] c_tgt;
  logic [TAG_W:0]    cnt_nx;
  // per-entry writeback selection; scanning channels downward lets the lowest index win
  always_comb begin
    hit = '0;
    hit_jump = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_data[i] = '0;
      hit_tgt[i] = '0;
      for (int c = NSRC - 1; c >= 0; c--)
        if (bus.wb_valid[c] && bus.wb_tag[c*TAG_W +: TAG_W] == TAG_W'(i)) begin
          hit[i] = 1'b1;
          hit_jump[i] = bus.wb_jump[c];
          hit_data[i] = bus.wb_data[c*DATA_W +: DATA_W];
          hit_tgt[i] = bus.wb_target[c*ADDR_W +: ADDR_W];
        end
    end
  end
`ifdef ROB_BYPASS_EN
  assign byp = busy[head] && !done[head] && hit[head];
`else
  assign byp = 1'b0;
`endif
  assign commit = (busy[head] && done[head]) || byp;
  assign c_jump = done[head] ? jump_q[head] : hit_jump[head];
  assign c_data = done[head] ? data_q[head] : hit_data[head];
  assign c_tgt = done[head] ? tgt_q[head] : hit_tgt[head];
  assign bus.alloc_ready = !bus.full && !(commit && c_jump);
  assign bus.alloc_tag = tail;
  assign alloc = bus.alloc_valid && bus.alloc_ready;
  assign cnt_nx = (commit && c_jump) ? '0 : bus.count + (TAG_W+1)'(alloc) - (TAG_W+1)'(commit);
  // entry storage, pointers, commit outputs; a taken jump wipes the queue after the writeback updates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      done <= '0;
      jump_q <= '0;
      rd_q <= '{default: '0};
      data_q <= '{default: '0};
      tgt_q <= '{default: '0};
      head <= '0;
      tail <= '0;
      bus.count <= '0;
      bus.empty <= 1'b1;
      bus.full <= 1'b0;
      bus.cmt_valid <= 1'b0;
      bus.cmt_rd <= '0;
      bus.cmt_data <= '0;
      bus.cmt_tag <= '0;
      bus.pc_we <= 1'b0;
      bus.pc_newpc <= '0;
      bus.flush <= 1'b0;
    end else begin
      bus.cmt_valid <= 1'b0;
      bus.pc_we <= 1'b0;
      bus.flush <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        if (hit[i] && busy[i] && !done[i] && !(byp && TAG_W'(i) == head)) begin
          done[i] <= 1'b1;
          data_q[i] <= hit_data[i];
          jump_q[i] <= hit_jump[i];
          tgt_q[i] <= hit_tgt[i];
        end
      if (commit) begin
        bus.cmt_valid <= 1'b1;
        bus.cmt_rd <= rd_q[head];
        bus.cmt_data <= c_data;
        bus.cmt_tag <= head;
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        head <= head + 1'b1;
        if (c_jump) begin
          bus.pc_we <= 1'b1;
          bus.pc_newpc <= c_tgt;
          bus.flush <= 1'b1;
          busy <= '0;
          done <= '0;
          tail <= head + 1'b1;
        end
      end
      if (alloc) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        rd_q[tail] <= bus.alloc_rd;
        tail <= tail + 1'b1;
      end
      bus.count <= cnt_nx;
      bus.empty <= cnt_nx == '0;
      bus.full <= cnt_nx == (TAG_W+1)'(DEPTH);
    end
  end
endmodule

// File: tb/tb_rob_queue.sv
// tb_rob_queue: directed vector table plus hand-written corner sequences for rob_queue
module tb_rob_queue;
  localparam int DEPTH = 8, NSRC = 3, DATA_W = 32, ADDR_W = 32, REG_W = 5, TAG_W = 3;
`ifdef ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  rob_queue_if #(.DEPTH(DEPTH), .NSRC(NSRC), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .TAG_W(TAG_W)) bus ();
  rob_queue #(.DEPTH(DEPTH), .NSRC(NSRC), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  rd;
    logic        wv;
    logic [2:0]  wt;
    logic [31:0] wd;
    logic        e_rdy;
    logic [2:0]  e_tag;
    logic        e_cv;
    logic [2:0]  e_ctag;
    logic [4:0]  e_crd;
    logic [31:0] e_cdata;
    logic [3:0]  e_cnt;
  } vec_t;
  vec_t v [10];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_wb;
    bus.wb_valid = '0;
    bus.wb_tag = '0;
    bus.wb_data = '0;
    bus.wb_jump = '0;
    bus.wb_target = '0;
  endtask

  task automatic idle;
    bus.alloc_valid = 1'b0;
    bus.alloc_rd = '0;
    clr_wb();
  endtask

  task automatic wb(input int ch, input logic [2:0] t, input logic [31:0] d, input logic j, input logic [31:0] tg);
    bus.wb_valid[ch] = 1'b1;
    bus.wb_tag[ch*TAG_W +: TAG_W] = t;
    bus.wb_data[ch*DATA_W +: DATA_W] = d;
    bus.wb_jump[ch] = j;
    bus.wb_target[ch*ADDR_W +: ADDR_W] = tg;
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic alloc_n(input int n, input logic [4:0] rd0);
    for (int k = 0; k < n; k++) begin
      bus.alloc_valid = 1'b1;
      bus.alloc_rd = rd0 + 5'(k);
      step();
    end
    bus.alloc_valid = 1'b0;
  endtask

  initial begin
    //        av rd    wv wt    wd      rdy tag  cv ctag  crd    cdata   cnt
    v[0] = '{1'b1, 5'd1, 1'b0, 3'd0, 32'h00, 1'b1, 3'd0, 1'b0, 3'd0, 5'd0, 32'h00, 4'd1};
    v[1] = '{1'b1, 5'd2, 1'b0, 3'd0, 32'h00, 1'b1, 3'd1, 1'b0, 3'd0, 5'd0, 32'h00, 4'd2};
    v[2] = '{1'b1, 5'd3, 1'b0, 3'd0, 32'h00, 1'b1, 3'd2, 1'b0, 3'd0, 5'd0, 32'h00, 4'd3};
    v[3] = '{1'b0, 5'd0, 1'b1, 3'd2, 32'h30, 1'b1, 3'd3, 1'b0, 3'd0, 5'd0, 32'h00, 4'd3};
    v[4] = '{1'b0, 5'd0, 1'b1, 3'd1, 32'h20, 1'b1, 3'd3, 1'b0, 3'd0, 5'd0, 32'h00, 4'd3};
    v[5] = '{1'b0, 5'd0, 1'b1, 3'd0, 32'h10, 1'b1, 3'd3, 1'b0, 3'd0, 5'd0, 32'h00, 4'd3};
    v[6] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h00, 1'b1, 3'd3, 1'b1, 3'd0, 5'd1, 32'h10, 4'd2};
    v[7] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h00, 1'b1, 3'd3, 1'b1, 3'd1, 5'd2, 32'h20, 4'd1};
    v[8] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h00, 1'b1, 3'd3, 1'b1, 3'd2, 5'd3, 32'h30, 4'd0};
    v[9] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h00, 1'b1, 3'd3, 1'b0, 3'd0, 5'd0, 32'h00, 4'd0};

    do_reset();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_cmt_valid", 32'(bus.cmt_valid), 0);
    chk("rst_pc_we", 32'(bus.pc_we), 0);
    chk("rst_flush", 32'(bus.flush), 0);
    chk("rst_alloc_ready", 32'(bus.alloc_ready), 1);
    chk("rst_alloc_tag", 32'(bus.alloc_tag), 0);

`ifndef ROB_BYPASS_EN
    for (int k = 0; k < 10; k++) begin
      bus.alloc_valid = v[k].av;
      bus.alloc_rd = v[k].rd;
      bus.wb_valid = {2'b00, v[k].wv};
      bus.wb_tag = {6'd0, v[k].wt};
      bus.wb_data = {64'd0, v[k].wd};
      bus.wb_jump = '0;
      bus.wb_target = '0;
      #1;
      chk($sformatf("v%0d_alloc_ready", k), 32'(bus.alloc_ready), 32'(v[k].e_rdy));
      chk($sformatf("v%0d_alloc_tag", k), 32'(bus.alloc_tag), 32'(v[k].e_tag));
      step();
      chk($sformatf("v%0d_cmt_valid", k), 32'(bus.cmt_valid), 32'(v[k].e_cv));
      if (v[k].e_cv) begin
        chk($sformatf("v%0d_cmt_tag", k), 32'(bus.cmt_tag), 32'(v[k].e_ctag));
        chk($sformatf("v%0d_cmt_rd", k), 32'(bus.cmt_rd), 32'(v[k].e_crd));
        chk($sformatf("v%0d_cmt_data", k), bus.cmt_data, v[k].e_cdata);
      end
      chk($sformatf("v%0d_count", k), 32'(bus.count), 32'(v[k].e_cnt));
    end
    idle();
    chk("order_empty", 32'(bus.empty), 1);
`endif

    // full queue, rejected 9th request, full blocks alloc during commit, tail wrap
    do_reset();
    alloc_n(8, 5'd1);
    chk("full_flag", 32'(bus.full), 1);
    chk("full_count", 32'(bus.count), 8);
    bus.alloc_valid = 1'b1;
    #1;
    chk("full_alloc_ready", 32'(bus.alloc_ready), 0);
    step();
    chk("full_ninth_rejected", 32'(bus.count), 8);
    wb(0, 3'd0, 32'h55, 1'b0, 32'h0);
    step();
    clr_wb();
    if (!BYP) step();
    chk("full_commit_tag", 32'(bus.cmt_tag), 0);
    chk("full_commit_blocks_alloc", 32'(bus.count), 7);
    bus.alloc_valid = 1'b0;
    #1;
    chk("wrap_alloc_ready", 32'(bus.alloc_ready), 1);
    chk("wrap_alloc_tag", 32'(bus.alloc_tag), 0);
    bus.alloc_valid = 1'b1;
    step();
    bus.alloc_valid = 1'b0;
    chk("wrap_refill_full", 32'(bus.full), 1);

    // taken jump at tag 1 flushes tags 2 and 3
    do_reset();
    alloc_n(4, 5'd4);
    wb(0, 3'd1, 32'h2, 1'b1, 32'h100);
    wb(1, 3'd2, 32'h3, 1'b0, 32'h0);
    step();
    clr_wb();
    wb(0, 3'd0, 32'h1, 1'b0, 32'h0);
    wb(1, 3'd3, 32'h4, 1'b0, 32'h0);
    step();
    clr_wb();
    if (!BYP) step();
    chk("jmp_c0_valid", 32'(bus.cmt_valid), 1);
    chk("jmp_c0_tag", 32'(bus.cmt_tag), 0);
    chk("jmp_c0_pc_we", 32'(bus.pc_we), 0);
    chk("jmp_alloc_blocked", 32'(bus.alloc_ready), 0);
    step();
    chk("jmp_c1_valid", 32'(bus.cmt_valid), 1);
    chk("jmp_c1_tag", 32'(bus.cmt_tag), 1);
    chk("jmp_pc_we", 32'(bus.pc_we), 1);
    chk("jmp_newpc", bus.pc_newpc, 32'h100);
    chk("jmp_flush", 32'(bus.flush), 1);
    chk("jmp_count", 32'(bus.count), 0);
    chk("jmp_empty", 32'(bus.empty), 1);
    chk("jmp_alloc_tag", 32'(bus.alloc_tag), 2);
    step();
    chk("jmp_after_valid", 32'(bus.cmt_valid), 0);
    chk("jmp_after_flush", 32'(bus.flush), 0);
    chk("jmp_after_pc_we", 32'(bus.pc_we), 0);
    step();
    chk("jmp_after2_valid", 32'(bus.cmt_valid), 0);

    // same-tag collision: lowest channel wins; writeback to a free tag is ignored
    do_reset();
    alloc_n(1, 5'd9);
    wb(0, 3'd0, 32'hA, 1'b0, 32'h0);
    wb(2, 3'd0, 32'hB, 1'b0, 32'h0);
    step();
    clr_wb();
    if (!BYP) step();
    chk("prio_valid", 32'(bus.cmt_valid), 1);
    chk("prio_data", bus.cmt_data, 32'hA);
    wb(1, 3'd5, 32'h77, 1'b0, 32'h0);
    step();
    clr_wb();
    step();
    chk("free_tag_no_commit", 32'(bus.cmt_valid), 0);
    chk("free_tag_count", 32'(bus.count), 0);

    // asynchronous reset mid-operation discards entries
    do_reset();
    alloc_n(3, 5'd1);
    wb(0, 3'd0, 32'h99, 1'b0, 32'h0);
    step();
    clr_wb();
    if (!BYP) step();
    chk("mid_pre_valid", 32'(bus.cmt_valid), 1);
    rst = 1'b0;
    #2;
    chk("mid_async_valid", 32'(bus.cmt_valid), 0);
    chk("mid_async_data", bus.cmt_data, 0);
    chk("mid_async_count", 32'(bus.count), 0);
    chk("mid_async_empty", 32'(bus.empty), 1);
    step();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mid_no_commit%0d", k), 32'(bus.cmt_valid), 0);
    end
    chk("mid_alloc_tag", 32'(bus.alloc_tag), 0);

    // commit latency relative to the writeback edge
    do_reset();
    alloc_n(1, 5'd2);
    wb(1, 3'd0, 32'h42, 1'b0, 32'h0);
    step();
    clr_wb();
    chk("lat_at_ew", 32'(bus.cmt_valid), 32'(BYP));
    step();
    chk("lat_at_ew1", 32'(bus.cmt_valid), 32'(!BYP));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
